fast_circle_stream_sampler: RTL

//   Next-generation FAST-16 circle sampler for the feature-extractor front end.

---
 rtl/fast_circle_stream_sampler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fast_circle_stream_sampler.sv
`default_nettype none
// ============================================================================
// Module   : fast_circle_stream_sampler
// Purpose  : Takes one 7x7 window per pixel in raster order, tracks the frame
//            position of the newest pixel, drops or flags border windows and
//            presents the centre pixel, the FAST-16 circle and the centre
//            coordinates through a single back-pressurable output register.
// Revision : 1.0 - initial release
// ============================================================================
module fast_circle_stream_sampler #(
  parameter int DATA_WIDTH      = 8,
  parameter int IMG_W           = 640,
  parameter int IMG_H           = 480,
  parameter int SUPPRESS_BORDER = 1,
  parameter int X_W             = $clog2(IMG_W),
  parameter int Y_W             = $clog2(IMG_H)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  window_valid,
  output logic                                  window_ready,
  input  logic                                  window_sof,
  input  logic                                  window_eof,
  input  logic [0:6][0:6][DATA_WIDTH-1:0]       window,
  output logic                                  circle_valid,
  input  logic                                  circle_ready,
  output logic                                  circle_sof,
  output logic                                  circle_eof,
  output logic                                  circle_border,
  output logic [X_W-1:0]                        center_x,
  output logic [Y_W-1:0]                        center_y,
  output logic [DATA_WIDTH-1:0]                 center_pixel,
  output logic [0:15][DATA_WIDTH-1:0]           circle_pixel,
  output logic                                  frame_err
);

  // Frame geometry constants sized to the coordinate counters.
  localparam logic [X_W-1:0] c_X_LAST   = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] c_Y_LAST   = Y_W'(IMG_H - 1);
  localparam logic [X_W-1:0] c_X_MARGIN = X_W'(6);
  localparam logic [Y_W-1:0] c_Y_MARGIN = Y_W'(6);
  localparam logic [X_W-1:0] c_X_OFF    = X_W'(3);
  localparam logic [Y_W-1:0] c_Y_OFF    = Y_W'(3);

  // FAST-16 circle tap positions (row, col) inside the 7x7 window.
  localparam int c_MAP_R [16] = '{0, 0, 1, 2, 3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0};
  localparam int c_MAP_C [16] = '{3, 4, 5, 6, 6, 6, 5, 4, 3, 2, 1, 0, 0, 0, 1, 2};

  // Expected position of the next beat and frame-tracking flags.
  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic           r_seen_sof;   // a sof has been accepted since reset
  logic           r_sof_pend;   // sof accepted but not yet attached to an output

  logic                         w_accept;
  logic [X_W-1:0]               w_pos_x;
  logic [Y_W-1:0]               w_pos_y;
  logic                         w_x_last;
  logic                         w_y_last;
  logic [X_W-1:0]               w_next_x;
  logic [Y_W-1:0]               w_next_y;
  logic                         w_border;
  logic                         w_emit;
  logic                         w_sof_err;
  logic                         w_eof_err;
  logic [0:15][DATA_WIDTH-1:0]  w_circle;

  // Single output register: a new beat can enter whenever the slot is free
  // or is being emptied this cycle.
  assign window_ready = !circle_valid | circle_ready;
  assign w_accept     = window_valid & window_ready;

  // A sof beat is always position (0,0), regardless of the counter.
  assign w_pos_x  = window_sof ? '0 : r_x;
  assign w_pos_y  = window_sof ? '0 : r_y;
  assign w_x_last = (w_pos_x == c_X_LAST);
  assign w_y_last = (w_pos_y == c_Y_LAST);
  assign w_next_x = w_x_last ? '0 : w_pos_x + 1'b1;
  assign w_next_y = w_x_last ? (w_y_last ? '0 : w_pos_y + 1'b1) : w_pos_y;

  // The window is incomplete until six earlier columns and rows exist.
  assign w_border = (w_pos_x < c_X_MARGIN) | (w_pos_y < c_Y_MARGIN);
  assign w_emit   = w_accept & (!w_border | (SUPPRESS_BORDER == 0));

  // Protocol checks; the first frame after reset may start anywhere.
  assign w_sof_err = window_sof & r_seen_sof & ((r_x != '0) | (r_y != '0));
  assign w_eof_err = window_eof & (window_sof | !(w_x_last & w_y_last));

  // Circle tap extraction.
  generate
    for (genvar i = 0; i < 16; i++) begin : g_circle
      assign w_circle[i] = window[c_MAP_R[i]][c_MAP_C[i]];
    end
  endgenerate

  // Position counter, sof bookkeeping and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_seen_sof <= 1'b0;
      r_sof_pend <= 1'b0;
      frame_err  <= 1'b0;
    end else if (w_accept) begin
      r_x        <= w_next_x;
      r_y        <= w_next_y;
      r_seen_sof <= r_seen_sof | window_sof;
      frame_err  <= frame_err | w_sof_err | w_eof_err;
      if (w_emit) begin
        r_sof_pend <= 1'b0;
      end else if (window_sof) begin
        r_sof_pend <= 1'b1;
      end
    end
  end

  // Output register: load on an emitted beat, hold while stalled, empty after transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      circle_valid  <= 1'b0;
      circle_sof    <= 1'b0;
      circle_eof    <= 1'b0;
      circle_border <= 1'b0;
      center_x      <= '0;
      center_y      <= '0;
      center_pixel  <= '0;
      circle_pixel  <= '0;
    end else if (w_emit) begin
      circle_valid  <= 1'b1;
      circle_sof    <= window_sof | r_sof_pend;
      circle_eof    <= window_eof;
      circle_border <= w_border;
      center_x      <= w_border ? '0 : w_pos_x - c_X_OFF;
      center_y      <= w_border ? '0 : w_pos_y - c_Y_OFF;
      center_pixel  <= window[3][3];
      circle_pixel  <= w_circle;
    end else if (circle_ready) begin
      circle_valid  <= 1'b0;
    end
  end

endmodule
`default_nettype wire
